tlk2711_rx_link_ctrl: RTL

TLK2711_RX_LINK_CTRL -- requirements
Module: tlk2711_rx_link_ctrl

---
 rtl/tlk2711_pkg.sv | 24 ++
 rtl/tlk2711_rx_sync_det.sv | 69 ++++++
 rtl/tlk2711_rx_link_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlk2711_pkg.sv
// Shared definitions for the TLK2711 receive link controller.
//   K_COMMA/K_SOF/K_EOF/K_IDLE : control codes, recognised only with rx_k == 2'b01
//   K_LSB                      : rx_k pattern marking a control code in the LSB byte
//   state_e                    : link controller states
//   CNT_W                      : width of the saturating statistics counters
package tlk2711_pkg;

  localparam int CNT_W = 16;

  localparam logic [15:0] K_COMMA = 16'h00BC;
  localparam logic [15:0] K_SOF   = 16'h00FB;
  localparam logic [15:0] K_EOF   = 16'h00FD;
  localparam logic [15:0] K_IDLE  = 16'h00F7;

  localparam logic [1:0]  K_LSB   = 2'b01;

  typedef enum logic [1:0] {
    ST_FLUSH  = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FRAME  = 2'd3
  } state_e;

endpackage

// File: rtl/tlk2711_rx_sync_det.sv
// Comma-run lock detector and bad-word-run loss detector.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   hunt_i     : controller is hunting for lock (comma counter enabled)
//   track_i    : controller is locked (loss counter enabled)
//   valid_i    : current input word is valid
//   comma_i    : current word is an error-free COMMA
//   bad_i      : current word is classified bad
//   lock_o     : combinational pulse, this word completes the comma run
//   loss_o     : combinational pulse, this word completes the bad-word run
module tlk2711_rx_sync_det
  import tlk2711_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hunt_i,
  input  logic track_i,
  input  logic valid_i,
  input  logic comma_i,
  input  logic bad_i,
  output logic lock_o,
  output logic loss_o
);

  localparam int LK_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam int LS_W = (LOSS_CNT > 1) ? $clog2(LOSS_CNT) : 1;

  logic [LK_W-1:0] comma_cnt_q, comma_cnt_d;
  logic [LS_W-1:0] loss_cnt_q, loss_cnt_d;

  // Pulses fire on the word that completes the run so the controller can
  // change state on the same clock edge that samples it.
  assign lock_o = hunt_i && valid_i && comma_i &&
                  (comma_cnt_q == LK_W'(LOCK_CNT - 1));
  assign loss_o = track_i && valid_i && bad_i &&
                  (loss_cnt_q == LS_W'(LOSS_CNT - 1));

  always_comb begin
    comma_cnt_d = comma_cnt_q;
    if (!hunt_i) begin
      comma_cnt_d = '0;
    end else if (valid_i) begin
      if (comma_i && !lock_o) comma_cnt_d = comma_cnt_q + 1'b1;
      else                    comma_cnt_d = '0;
    end

    loss_cnt_d = loss_cnt_q;
    if (!track_i) begin
      loss_cnt_d = '0;
    end else if (valid_i) begin
      if (bad_i && !loss_o) loss_cnt_d = loss_cnt_q + 1'b1;
      else                  loss_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      comma_cnt_q <= '0;
      loss_cnt_q  <= '0;
    end else begin
      comma_cnt_q <= comma_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
    end
  end

endmodule

// File: rtl/tlk2711_rx_link_ctrl.sv
// TLK2711 receive link controller: flushes the RX CDC FIFO, hunts for comma
// lock, tracks link loss and extracts SOF/EOF delimited payload frames.
// Optional build macro: TLK2711_RX_LEN_CHECK_EN adds a payload length limit of
// MAX_LEN words per frame; without it frames are unbounded.
// Ports:
//   clk, rst_n               : clock (FIFO read side), asynchronous active-low reset
//   i_rx_valid               : FIFO output word valid
//   i_rx_data, i_rx_k        : received word and K flags (bit1 = MSB byte)
//   i_rx_err                 : code error for this word
//   o_soft_rst               : soft reset to the CDC FIFO
//   o_locked                 : link lock status
//   o_data/o_valid/o_sof/o_eof : payload stream (registered)
//   o_frame_cnt, o_err_cnt   : saturating statistics counters
module tlk2711_rx_link_ctrl
  import tlk2711_pkg::*;
#(
  parameter int DATAWIDTH = 16,
  parameter int LOCK_CNT  = 4,
  parameter int LOSS_CNT  = 8,
  parameter int RST_HOLD  = 16,
  parameter int MAX_LEN   = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_rx_valid,
  input  logic [DATAWIDTH-1:0] i_rx_data,
  input  logic [1:0]           i_rx_k,
  input  logic                 i_rx_err,
  output logic                 o_soft_rst,
  output logic                 o_locked,
  output logic [DATAWIDTH-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_sof,
  output logic                 o_eof,
  output logic [CNT_W-1:0]     o_frame_cnt,
  output logic [CNT_W-1:0]     o_err_cnt
);

  localparam int FL_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  if (MAX_LEN < 1) begin : g_bad_max_len
    $error("MAX_LEN must be at least 1");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic inc);
    if (inc && (v != {CNT_W{1'b1}})) return v + 1'b1;
    return v;
  endfunction

  // Word classification
  logic m_comma, m_sof, m_eof, m_idle, m_known;
  logic w_bad, w_comma, w_sof, w_eof, w_data;

  always_comb begin
    m_comma = (i_rx_k == K_LSB) && (i_rx_data == DATAWIDTH'(K_COMMA));
    m_sof   = (i_rx_k == K_LSB) && (i_rx_data == DATAWIDTH'(K_SOF));
    m_eof   = (i_rx_k == K_LSB) && (i_rx_data == DATAWIDTH'(K_EOF));
    m_idle  = (i_rx_k == K_LSB) && (i_rx_data == DATAWIDTH'(K_IDLE));
    m_known = m_comma || m_sof || m_eof || m_idle;
    w_bad   = i_rx_err || ((i_rx_k != 2'b00) && !m_known);
    w_comma = m_comma && !w_bad;
    w_sof   = m_sof   && !w_bad;
    w_eof   = m_eof   && !w_bad;
    w_data  = (i_rx_k == 2'b00) && !w_bad;
  end

  state_e               state_q, state_d;
  logic [FL_W-1:0]      flush_cnt_q, flush_cnt_d;
  logic                 soft_rst_q, soft_rst_d;
  logic                 locked_q, locked_d;
  logic [DATAWIDTH-1:0] buf_q;
  logic                 buf_vld_q, buf_vld_d;
  logic                 buf_sof_q, buf_sof_d;
  logic                 first_q, first_d;
  logic [DATAWIDTH-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 sof_q, sof_d;
  logic                 eof_q, eof_d;
  logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
`ifdef TLK2711_RX_LEN_CHECK_EN
  localparam int LEN_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  logic [LEN_W-1:0]     len_q, len_d;
  logic                 drop_q, drop_d;
`endif

  logic lock_pulse, loss_pulse;
  logic store, emit, emit_eof, err_inc, frame_inc;

  tlk2711_rx_sync_det #(
    .LOCK_CNT (LOCK_CNT),
    .LOSS_CNT (LOSS_CNT)
  ) u_sync_det (
    .clk     (clk),
    .rst_n   (rst_n),
    .hunt_i  (state_q == ST_HUNT),
    .track_i ((state_q == ST_LOCKED) || (state_q == ST_FRAME)),
    .valid_i (i_rx_valid),
    .comma_i (w_comma),
    .bad_i   (w_bad),
    .lock_o  (lock_pulse),
    .loss_o  (loss_pulse)
  );

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    soft_rst_d  = soft_rst_q;
    locked_d    = locked_q;
    buf_vld_d   = buf_vld_q;
    buf_sof_d   = buf_sof_q;
    first_d     = first_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    sof_d       = 1'b0;
    eof_d       = 1'b0;
    store       = 1'b0;
    emit        = 1'b0;
    emit_eof    = 1'b0;
    err_inc     = 1'b0;
    frame_inc   = 1'b0;
`ifdef TLK2711_RX_LEN_CHECK_EN
    len_d       = len_q;
    drop_d      = drop_q;
`endif

    case (state_q)
      ST_FLUSH: begin
        // The hold counts every cycle regardless of input activity.
        if (flush_cnt_q == FL_W'(RST_HOLD - 1)) begin
          state_d     = ST_HUNT;
          soft_rst_d  = 1'b0;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end

      ST_HUNT: begin
        if (lock_pulse) begin
          state_d  = ST_LOCKED;
          locked_d = 1'b1;
        end
      end

      ST_LOCKED: begin
        // A word left buffered by a length-limit close is released here.
        if (buf_vld_q) begin
          emit     = 1'b1;
          emit_eof = 1'b1;
        end
        if (i_rx_valid) begin
          if (w_bad) begin
            err_inc = 1'b1;
          end else if (w_sof) begin
            state_d = ST_FRAME;
            first_d = 1'b1;
`ifdef TLK2711_RX_LEN_CHECK_EN
            len_d   = '0;
            drop_d  = 1'b0;
`endif
          end else if (w_eof) begin
            err_inc = 1'b1;
          end else if (w_data) begin
`ifdef TLK2711_RX_LEN_CHECK_EN
            err_inc = !drop_q;
`else
            err_inc = 1'b1;
`endif
          end
        end
      end

      ST_FRAME: begin
        if (i_rx_valid) begin
          if (w_bad) begin
            err_inc = 1'b1;
          end else if (w_data) begin
            // Hold the newest word back so a following EOF can tag it.
            emit      = buf_vld_q;
            store     = 1'b1;
            buf_vld_d = 1'b1;
            buf_sof_d = first_q;
            first_d   = 1'b0;
`ifdef TLK2711_RX_LEN_CHECK_EN
            if (len_q == LEN_W'(MAX_LEN - 1)) begin
              err_inc = 1'b1;
              state_d = ST_LOCKED;
              drop_d  = 1'b1;
            end else begin
              len_d = len_q + 1'b1;
            end
`endif
          end else if (w_eof) begin
            if (buf_vld_q) begin
              emit      = 1'b1;
              emit_eof  = 1'b1;
              frame_inc = 1'b1;
            end else begin
              err_inc = 1'b1;
            end
            state_d = ST_LOCKED;
          end else if (w_sof) begin
            // Close the running frame on its last word and restart.
            if (buf_vld_q) begin
              emit      = 1'b1;
              emit_eof  = 1'b1;
              frame_inc = 1'b1;
            end
            err_inc = 1'b1;
            first_d = 1'b1;
`ifdef TLK2711_RX_LEN_CHECK_EN
            len_d   = '0;
`endif
          end
        end
      end

      default: state_d = ST_FLUSH;
    endcase

    if (loss_pulse) begin
      if (buf_vld_q) begin
        emit     = 1'b1;
        emit_eof = 1'b1;
      end
      state_d     = ST_FLUSH;
      locked_d    = 1'b0;
      soft_rst_d  = 1'b1;
      flush_cnt_d = '0;
      first_d     = 1'b0;
`ifdef TLK2711_RX_LEN_CHECK_EN
      drop_d      = 1'b0;
`endif
    end

    if (emit) begin
      valid_d = 1'b1;
      data_d  = buf_q;
      sof_d   = buf_sof_q;
      eof_d   = emit_eof;
      if (!store) buf_vld_d = 1'b0;
    end

    frame_cnt_d = sat_inc(frame_cnt_q, frame_inc);
    err_cnt_d   = sat_inc(err_cnt_q, err_inc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FLUSH;
      flush_cnt_q <= '0;
      soft_rst_q  <= 1'b1;
      locked_q    <= 1'b0;
      buf_vld_q   <= 1'b0;
      buf_sof_q   <= 1'b0;
      first_q     <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
`ifdef TLK2711_RX_LEN_CHECK_EN
      len_q       <= '0;
      drop_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      soft_rst_q  <= soft_rst_d;
      locked_q    <= locked_d;
      buf_vld_q   <= buf_vld_d;
      buf_sof_q   <= buf_sof_d;
      first_q     <= first_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
`ifdef TLK2711_RX_LEN_CHECK_EN
      len_q       <= len_d;
      drop_q      <= drop_d;
`endif
    end
  end

  // Payload holding register: data only, qualified by buf_vld_q.
  always_ff @(posedge clk) begin
    if (store) buf_q <= i_rx_data;
  end

  assign o_soft_rst  = soft_rst_q;
  assign o_locked    = locked_q;
  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_sof       = sof_q;
  assign o_eof       = eof_q;
  assign o_frame_cnt = frame_cnt_q;
  assign o_err_cnt   = err_cnt_q;

endmodule
